// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR sequencer: FSM state encoding,
// the default feedback taps and a width-generic Fibonacci step function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // x^3 + x^2 + 1, maximal length (period 7) for a 3-bit register
  localparam logic [2:0] TAPS_DEF = 3'b110;

  localparam int unsigned MAX_W = 64;

  // Shift left by one and insert the XOR of the tapped bits at bit 0.
  // Operands are zero-extended to MAX_W so one function serves every WIDTH.
  function automatic logic [MAX_W-1:0] lfsr_next(
    input logic [MAX_W-1:0] cur,
    input logic [MAX_W-1:0] taps,
    input int unsigned      width
  );
    logic [MAX_W-1:0] mask;
    logic             fb;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    fb   = ^(cur & taps & mask);
    return ((cur << 1) | MAX_W'(fb)) & mask;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR shift register. A load takes priority over a step, and the
// register holds its value when neither is asserted.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(TAPS_DEF),
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] step_val;

  assign step_val = WIDTH'(lfsr_next(MAX_W'(q_q), MAX_W'(TAPS), WIDTH));

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      q_d = step_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Run-length sequencer around lfsr_core: config registers, FSM and beat counter.
// Optional feature LFSR_CTRL_WRAP_EN adds a registered 'wrap' period marker.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 3,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS_DEF),
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] SEED_DEF = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_seed,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup_err
`ifdef LFSR_CTRL_WRAP_EN
  ,
  output logic             wrap
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             lockup_q, lockup_d;
  logic             beat;
  logic             lfsr_load;
  logic [WIDTH-1:0] lfsr_q;

  lfsr_core #(
    .WIDTH     (WIDTH),
    .TAPS      (TAPS),
    .RESET_VAL (SEED_DEF)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (seed_q),
    .step     (beat),
    .q        (lfsr_q)
  );

  // An all-zero seed would lock the LFSR, so it is replaced by 1 and flagged.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    len_d     = len_q;
    rem_d     = rem_q;
    lockup_d  = lockup_q;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    lfsr_load = 1'b0;
    beat      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          len_d = cfg_len;
          if (cfg_seed == '0) begin
            seed_d   = WIDTH'(1);
            lockup_d = 1'b1;
          end else begin
            seed_d = cfg_seed;
          end
        end
        if (start) begin
          state_d = (len_q != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        busy      = 1'b1;
        lfsr_load = 1'b1;
        rem_d     = len_q;
        state_d   = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        beat      = out_ready;
        if (out_ready) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      seed_q   <= SEED_DEF;
      len_q    <= '0;
      rem_q    <= '0;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      seed_q   <= seed_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      lockup_q <= lockup_d;
    end
  end

  assign out_data   = lfsr_q;
  assign lockup_err = lockup_q;

`ifdef LFSR_CTRL_WRAP_EN
  // A beat whose successor equals the seed closes one full period.
  logic [WIDTH-1:0] lfsr_nx;
  logic             wrap_q;

  assign lfsr_nx = WIDTH'(lfsr_next(MAX_W'(lfsr_q), MAX_W'(TAPS), WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= beat && (lfsr_nx == seed_q);
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl (default parameters), with a
// behavioural reference model of the x^3+x^2+1 sequence and config registers.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [2:0] cfg_seed;
  logic [7:0] cfg_len;
  logic       start;
  logic       busy;
  logic       done;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       lockup_err;
`ifdef LFSR_CTRL_WRAP_EN
  logic       wrap;
`endif

  int checks = 0;
  int errors = 0;

  logic [2:0] gotBeats[$];
  logic [2:0] expQ[$];
  int         firstValid;
  int         doneCycle;
  int         busyCount;
  int         stallErrs;
  int         wrapCount;
  logic [2:0] mSeed;
  int         mLen;
  bit         mLockup;
  logic [2:0] tbl [7];

  always #5 clk = ~clk;

  lfsr_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_seed   (cfg_seed),
    .cfg_len    (cfg_len),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .lockup_err (lockup_err)
`ifdef LFSR_CTRL_WRAP_EN
    ,
    .wrap       (wrap)
`endif
  );

  // Reference step: double modulo 8, feedback is parity of bits 2 and 1.
  function automatic logic [2:0] refNext(input logic [2:0] s);
    int v;
    int fb;
    v  = int'(s);
    fb = ((v / 4) % 2) ^ ((v / 2) % 2);
    return 3'(((v * 2) % 8) + fb);
  endfunction

  function automatic void buildExp(input logic [2:0] seed, input int len);
    logic [2:0] s;
    expQ.delete();
    s = seed;
    for (int i = 0; i < len; i++) begin
      expQ.push_back(s);
      s = refNext(s);
    end
  endfunction

  function automatic int expWraps(input logic [2:0] seed);
    int n;
    n = 0;
    foreach (expQ[i]) if (refNext(expQ[i]) == seed) n++;
    return n;
  endfunction

  function automatic void modelCfg(input logic [2:0] seed, input int len);
    if (seed == 3'd0) begin
      mSeed   = 3'd1;
      mLockup = 1'b1;
    end else begin
      mSeed = seed;
    end
    mLen = len;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [2:0] seed, input logic [7:0] len);
    cfg_we   = 1'b1;
    cfg_seed = seed;
    cfg_len  = len;
    tick();
    cfg_we = 1'b0;
    modelCfg(seed, int'(len));
  endtask

  // Pulses start and follows the run until done (mode 0: ready=1, 1: ready
  // every third cycle, 2: random ready, 3: ready=1 plus start/cfg in RUN).
  task automatic doRun(input int mode, input int budget);
    logic [2:0] lastData;
    bit         lastStalled;
    gotBeats.delete();
    firstValid  = -1;
    doneCycle   = -1;
    busyCount   = 0;
    stallErrs   = 0;
    wrapCount   = 0;
    lastStalled = 1'b0;
    lastData    = '0;
    for (int c = 0; c < budget; c++) begin
      start  = (c == 0) || (mode == 3 && c == 4);
      cfg_we = (mode == 3 && c == 4);
      if (mode == 3 && c == 4) begin
        cfg_seed = 3'd5;
        cfg_len  = 8'd2;
      end
      case (mode)
        1:       out_ready = ((c % 3) == 0);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (out_valid && firstValid < 0) firstValid = c;
      if (busy) busyCount++;
      if (lastStalled && out_valid && out_data !== lastData) stallErrs++;
      if (out_valid && out_ready) gotBeats.push_back(out_data);
      lastStalled = out_valid && !out_ready;
      lastData    = out_data;
`ifdef LFSR_CTRL_WRAP_EN
      if (wrap) wrapCount++;
`endif
      if (done) begin
        doneCycle = c;
        break;
      end
      tick();
    end
    start     = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mSeed = 3'd1; mLen = 0; mLockup = 1'b0;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", done); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
    if (lockup_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_lockup got %0b want 0", lockup_err); end
    if (out_data !== 3'd1) begin errors++; $display("[TB] FAIL reset_data got %0d want 1", out_data); end
  endtask

  task automatic test_zero_len();
    doRun(0, 10);
    checks += 4;
    if (doneCycle !== 1) begin errors++; $display("[TB] FAIL zlen_done_cycle got %0d want 1", doneCycle); end
    if (gotBeats.size() != 0) begin errors++; $display("[TB] FAIL zlen_beats got %0d want 0", gotBeats.size()); end
    if (busyCount != 0) begin errors++; $display("[TB] FAIL zlen_busy got %0d want 0", busyCount); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL zlen_done_width got %0b want 0", done); end
  endtask

  task automatic test_full_period();
    cfgWrite(3'd1, 8'd7);
    doRun(0, 40);
    checks += 5;
    if (firstValid != 2) begin errors++; $display("[TB] FAIL full_latency got %0d want 2", firstValid); end
    if (doneCycle != 9) begin errors++; $display("[TB] FAIL full_done_cycle got %0d want 9", doneCycle); end
    if (busyCount != 8) begin errors++; $display("[TB] FAIL full_busy_cycles got %0d want 8", busyCount); end
    if (gotBeats.size() != 7) begin errors++; $display("[TB] FAIL full_beats got %0d want 7", gotBeats.size()); end
    if (out_data !== 3'd1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL full_idle_data got %0d/%0b want 1/0", out_data, out_valid);
    end
    for (int i = 0; i < 7 && i < gotBeats.size(); i++) begin
      checks++;
      if (gotBeats[i] !== tbl[i]) begin errors++; $display("[TB] FAIL full_beat%0d got %0d want %0d", i, gotBeats[i], tbl[i]); end
    end
`ifdef LFSR_CTRL_WRAP_EN
    checks++;
    if (wrapCount != 1) begin errors++; $display("[TB] FAIL full_wrap got %0d want 1", wrapCount); end
`endif
  endtask

  task automatic test_stall();
    cfgWrite(3'd1, 8'd7);
    buildExp(mSeed, mLen);
    doRun(1, 60);
    checks += 3;
    if (stallErrs != 0) begin errors++; $display("[TB] FAIL stall_stable got %0d changes want 0", stallErrs); end
    if (gotBeats.size() != 7) begin errors++; $display("[TB] FAIL stall_beats got %0d want 7", gotBeats.size()); end
    if (doneCycle != 22) begin errors++; $display("[TB] FAIL stall_done_cycle got %0d want 22", doneCycle); end
    for (int i = 0; i < expQ.size() && i < gotBeats.size(); i++) begin
      checks++;
      if (gotBeats[i] !== expQ[i]) begin errors++; $display("[TB] FAIL stall_beat%0d got %0d want %0d", i, gotBeats[i], expQ[i]); end
    end
`ifdef LFSR_CTRL_WRAP_EN
    checks++;
    if (wrapCount != 1) begin errors++; $display("[TB] FAIL stall_wrap got %0d want 1", wrapCount); end
`endif
  endtask

  task automatic test_lockup();
    cfgWrite(3'd0, 8'd3);
    checks += 2;
    if (lockup_err !== 1'b1) begin errors++; $display("[TB] FAIL lockup_flag got %0b want 1", lockup_err); end
    doRun(0, 20);
    if (gotBeats.size() != 3) begin errors++; $display("[TB] FAIL lockup_beats got %0d want 3", gotBeats.size()); end
    buildExp(3'd1, 3);
    for (int i = 0; i < 3 && i < gotBeats.size(); i++) begin
      checks++;
      if (gotBeats[i] !== expQ[i]) begin errors++; $display("[TB] FAIL lockup_beat%0d got %0d want %0d", i, gotBeats[i], expQ[i]); end
    end
  endtask

  task automatic test_ignore_during_run();
    cfgWrite(3'd3, 8'd5);
    buildExp(mSeed, mLen);
    for (int r = 0; r < 2; r++) begin
      doRun((r == 0) ? 3 : 0, 40);
      checks += 2;
      if (gotBeats.size() != expQ.size()) begin
        errors++; $display("[TB] FAIL ignore_run%0d_beats got %0d want %0d", r, gotBeats.size(), expQ.size());
      end
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_run%0d_requeued got busy %0b want 0", r, busy); end
      for (int i = 0; i < expQ.size() && i < gotBeats.size(); i++) begin
        checks++;
        if (gotBeats[i] !== expQ[i]) begin
          errors++; $display("[TB] FAIL ignore_run%0d_beat%0d got %0d want %0d", r, i, gotBeats[i], expQ[i]);
        end
      end
    end
    checks++;
    if (lockup_err !== 1'b1) begin errors++; $display("[TB] FAIL ignore_lockup_sticky got %0b want 1", lockup_err); end
  endtask

  task automatic test_reset_mid_run();
    int nBeats;
    int doneSeen;
    cfgWrite(3'd1, 8'd7);
    nBeats = 0;
    start = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && nBeats < 3; c++) begin
      if (out_valid && out_ready) nBeats++;
      tick();
      start = 1'b0;
    end
    checks++;
    if (nBeats != 3) begin errors++; $display("[TB] FAIL midrst_reach got %0d beats want 3", nBeats); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    mSeed = 3'd1; mLen = 0; mLockup = 1'b0;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %0b want 0", out_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %0b want 0", busy); end
    if (out_data !== 3'd1) begin errors++; $display("[TB] FAIL midrst_data got %0d want 1", out_data); end
    if (lockup_err !== 1'b0) begin errors++; $display("[TB] FAIL midrst_lockup got %0b want 0", lockup_err); end
    doneSeen = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) doneSeen++;
      tick();
    end
    if (doneSeen != 0) begin errors++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", doneSeen); end
    doRun(0, 10);
    checks++;
    if (doneCycle != 1 || gotBeats.size() != 0) begin
      errors++; $display("[TB] FAIL midrst_len_cleared got done@%0d beats %0d want done@1 beats 0", doneCycle, gotBeats.size());
    end
  endtask

  task automatic test_random();
    logic [2:0] seed;
    logic [7:0] len;
    for (int it = 0; it < 8; it++) begin
      seed = 3'($urandom_range(0, 7));
      len  = 8'($urandom_range(1, 20));
      cfgWrite(seed, len);
      buildExp(mSeed, mLen);
      doRun(2, 400);
      checks += 3;
      if (gotBeats.size() != expQ.size()) begin
        errors++; $display("[TB] FAIL rand%0d_beats got %0d want %0d", it, gotBeats.size(), expQ.size());
      end
      if (stallErrs != 0) begin errors++; $display("[TB] FAIL rand%0d_stable got %0d changes want 0", it, stallErrs); end
      if (lockup_err !== mLockup) begin errors++; $display("[TB] FAIL rand%0d_lockup got %0b want %0b", it, lockup_err, mLockup); end
      for (int i = 0; i < expQ.size() && i < gotBeats.size(); i++) begin
        checks++;
        if (gotBeats[i] !== expQ[i]) begin
          errors++; $display("[TB] FAIL rand%0d_beat%0d got %0d want %0d", it, i, gotBeats[i], expQ[i]);
        end
      end
`ifdef LFSR_CTRL_WRAP_EN
      checks++;
      if (wrapCount != expWraps(mSeed)) begin
        errors++; $display("[TB] FAIL rand%0d_wrap got %0d want %0d", it, wrapCount, expWraps(mSeed));
      end
`endif
    end
  endtask

  initial begin
    tbl = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};
    rst = 1'b1; cfg_we = 1'b0; cfg_seed = '0; cfg_len = '0;
    start = 1'b0; out_ready = 1'b0;
    test_reset();
    test_zero_len();
    test_full_period();
    test_stall();
    test_lockup();
    test_ignore_during_run();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
